// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and defaults for the counter step control stage
//
// Contents:
//   step_state_t          FSM state encoding for counter_step_ctrl
//   DEF_DEBOUNCE_CYCLES   default stable cycles to accept a press or release
//   DEF_REPEAT_DELAY      default cycles from press pulse to first repeat pulse
//   DEF_REPEAT_PERIOD     default cycles between later repeat pulses
//   cnt_width()           width of a counter that must reach max_val-1 without wrapping
package counter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_RELEASE
  } step_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 16;
  localparam int DEF_REPEAT_PERIOD   = 8;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer for asynchronous inputs
//
// Ports:
//   clock   in  single clock, rising edge
//   reset   in  synchronous active-low reset, clears both stages
//   d       in  asynchronous input
//   q       out synchronized output, two clock edges behind d
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/counter_step_ctrl.sv
// rtl/counter_step_ctrl.sv - push-button to one-cycle counter step pulses with debounce and auto-repeat
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles to accept a press or release (>=1)
//   REPEAT_DELAY     cycles from the press pulse to the first repeat pulse (>=2)
//   REPEAT_PERIOD    cycles between later repeat pulses (>=2)
// Ports:
//   clock          in  single clock, rising edge
//   reset          in  synchronous active-low reset
//   button_in      in  raw asynchronous push-button, active-high
//   repeat_en      in  auto-repeat while held when 1
//   enable         out registered one-cycle step pulse for the counter
//   pressed        out registered debounced button level
//   repeat_active  out registered, high while auto-repeating
module counter_step_ctrl
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  input  logic repeat_en,
  output logic enable,
  output logic pressed,
  output logic repeat_active
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW      = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW      = cnt_width(RPT_MAX);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          s2;
  step_state_t   state;
  logic [DW-1:0] deb_cnt;
  logic [RW-1:0] rpt_cnt;

  sync_2ff u_sync_button (
    .clock (clock),
    .reset (reset),
    .d     (button_in),
    .q     (s2)
  );

  // Counters are cleared on every state change, so they only ever count up
  // to their terminal value and cannot wrap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      rpt_cnt       <= '0;
      enable        <= 1'b0;
      pressed       <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      enable <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state   <= DEB_PRESS;
            deb_cnt <= '0;
          end
        end

        DEB_PRESS: begin
          if (!s2) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= HELD;
            rpt_cnt <= '0;
            enable  <= 1'b1;
            pressed <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        HELD: begin
          if (!s2) begin
            state   <= DEB_RELEASE;
            deb_cnt <= '0;
          end else if (!repeat_en) begin
            rpt_cnt <= '0;
          end else if (rpt_cnt == DELAY_LAST) begin
            state         <= REPEAT;
            rpt_cnt       <= '0;
            enable        <= 1'b1;
            repeat_active <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end

        REPEAT: begin
          // Release is checked first so a falling button suppresses a due pulse.
          if (!s2) begin
            state         <= DEB_RELEASE;
            deb_cnt       <= '0;
            repeat_active <= 1'b0;
          end else if (!repeat_en) begin
            state         <= HELD;
            rpt_cnt       <= '0;
            repeat_active <= 1'b0;
          end else if (rpt_cnt == PERIOD_LAST) begin
            rpt_cnt <= '0;
            enable  <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end

        DEB_RELEASE: begin
          // A bounce back high is treated as still held; the repeat timer restarts.
          if (s2) begin
            state   <= HELD;
            rpt_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= IDLE;
            pressed <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          deb_cnt       <= '0;
          rpt_cnt       <= '0;
          pressed       <= 1'b0;
          repeat_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
